ir_prefetch_queue: RTL and testbench

//  Parametrised successor to the single-word instruction register: a DEPTH-entry prefetch queue between the memory read port and the control unit.

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_fifo_core.sv | 80 ++++++++
 rtl/ir_prefetch_queue.sv | 158 +++++++++++++++
 tb/tb_ir_prefetch_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the instruction prefetch queue and its users:
//   IR_DATA_W / IR_DEPTH : default word width and queue depth
//   OPC_MSB / OPC_LSB    : opcode field bounds inside an instruction word
//   ir_op_e              : per-cycle operation chosen by the queue's priority
//   ir_opcode()          : extracts the opcode field for CU decode
// ---------------------------------------------------------------------------
package ir_pkg;

   localparam int IR_DATA_W = 16;
   localparam int IR_DEPTH  = 4;
   localparam int OPC_MSB   = 15;
   localparam int OPC_LSB   = 12;

   // Highest-priority action wins: reset > load > flush > normal streaming.
   typedef enum logic [1:0] {
      IR_OP_STREAM = 2'd0,
      IR_OP_FLUSH  = 2'd1,
      IR_OP_LOAD   = 2'd2,
      IR_OP_RESET  = 2'd3
   } ir_op_e;

   function automatic logic [OPC_MSB-OPC_LSB:0] ir_opcode(input logic [IR_DATA_W-1:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/ir_fifo_core.sv
// ---------------------------------------------------------------------------
// ir_fifo_core
// Storage array, read/write pointers and occupancy counter of the prefetch
// queue. Priority between the control inputs is rst > load > clear > push/pop.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               empty the queue (pointers back to 0)
//   load, load_data     make load_data the only entry (slot 0)
//   push, push_data     append push_data at the tail
//   pop                 drop the head (ignored when empty)
//   head                raw storage at the read pointer (caller qualifies it)
//   count               occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ir_fifo_core #(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              do_pop_s;
   logic              do_push_s;

   // A push into a full queue is only legal when a pop frees the head slot.
   assign do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
   assign do_push_s = push & ((count_r < CNT_W'(DEPTH)) | do_pop_s);

   // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (load) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= PTR_W'(1);
         count_r  <= CNT_W'(1);
      end else if (clear) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage writes; contents are don't-care while count marks them invalid, so no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         mem_r[0] <= load_data;
      end else if (do_push_s && !clear) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ir_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ir_prefetch_queue
// DEPTH-entry instruction prefetch queue between the memory read port and the
// control unit. The head entry is presented on to_cu; the CU pops it with
// cu_next; the internal data bus can load (write_en) or read (read_en) the
// current instruction.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_rd_data/mem_rd_valid   word returned by memory
//   mem_rd_req                 registered request for the next fetch
//   write_en, data_in          load data_in as the sole queue entry
//   read_en, data_out          head onto the bus (0 when not reading/empty)
//   flush                      discard all entries
//   cu_next                    CU consumes the head
//   to_cu, to_cu_valid         head instruction and its valid
//   count                      occupancy
//   overflow                   sticky: a memory word was dropped while full
// Build option: define IR_BYPASS_EN to let a memory word reach to_cu in the
// same cycle it arrives when the queue is empty.
// ---------------------------------------------------------------------------
module ir_prefetch_queue
   import ir_pkg::*;
#(
   parameter  int DATA_W = IR_DATA_W,
   parameter  int DEPTH  = IR_DEPTH,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid,
   output logic              mem_rd_req,
   input  logic              write_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_en,
   output logic [DATA_W-1:0] data_out,
   input  logic              flush,
   input  logic              cu_next,
   output logic [DATA_W-1:0] to_cu,
   output logic              to_cu_valid,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   ir_op_e            op_s;
   logic              stream_s;
   logic [CNT_W-1:0]  count_s;
   logic [DATA_W-1:0] head_s;
   logic              nonempty_s;
   logic              full_s;
   logic              bypass_hit_s;
   logic              byp_consume_s;
   logic              pop_s;
   logic              core_pop_s;
   logic              push_s;
   logic              drop_s;
   logic [CNT_W-1:0]  next_count_s;
   logic [DATA_W-1:0] to_cu_s;
   logic              req_r;
   logic              ovf_r;

   // Resolve the per-cycle priority into a single operation.
   always_comb begin
      op_s = IR_OP_STREAM;
      if (rst) begin
         op_s = IR_OP_RESET;
      end else if (write_en) begin
         op_s = IR_OP_LOAD;
      end else if (flush) begin
         op_s = IR_OP_FLUSH;
      end else begin
         op_s = IR_OP_STREAM;
      end
   end

   assign stream_s   = (op_s == IR_OP_STREAM);
   assign nonempty_s = (count_s != {CNT_W{1'b0}});
   assign full_s     = (count_s == CNT_W'(DEPTH));

`ifdef IR_BYPASS_EN
   assign bypass_hit_s = stream_s & ~nonempty_s & mem_rd_valid;
`else
   assign bypass_hit_s = 1'b0;
`endif

   assign to_cu_valid = nonempty_s | bypass_hit_s;

   // A bypassed word taken by the CU in the same cycle never touches storage.
   assign byp_consume_s = bypass_hit_s & cu_next;
   assign pop_s         = stream_s & cu_next & to_cu_valid;
   assign core_pop_s    = pop_s & ~byp_consume_s;
   assign push_s        = stream_s & mem_rd_valid & (~full_s | core_pop_s) & ~byp_consume_s;
   assign drop_s        = stream_s & mem_rd_valid & full_s & ~pop_s;

   // Head selection: stored head first, then a bypassed memory word, else 0.
   always_comb begin
      to_cu_s = {DATA_W{1'b0}};
      if (nonempty_s) begin
         to_cu_s = head_s;
      end else if (bypass_hit_s) begin
         to_cu_s = mem_rd_data;
      end else begin
         to_cu_s = {DATA_W{1'b0}};
      end
   end

   // Occupancy after this edge, used to decide whether another fetch fits.
   always_comb begin
      next_count_s = count_s;
      case (op_s)
         IR_OP_LOAD:   next_count_s = CNT_W'(1);
         IR_OP_FLUSH:  next_count_s = {CNT_W{1'b0}};
         IR_OP_RESET:  next_count_s = {CNT_W{1'b0}};
         IR_OP_STREAM: begin
            case ({push_s, core_pop_s})
               2'b10:   next_count_s = count_s + CNT_W'(1);
               2'b01:   next_count_s = count_s - CNT_W'(1);
               default: next_count_s = count_s;
            endcase
         end
         default:      next_count_s = count_s;
      endcase
   end

   // Fetch request keeps one spare slot for the word already in flight; overflow is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_r <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         req_r <= stream_s & (next_count_s < CNT_W'(DEPTH - 1));
         ovf_r <= ovf_r | drop_s;
      end
   end

   ir_fifo_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .clear     (op_s == IR_OP_FLUSH),
      .load      (op_s == IR_OP_LOAD),
      .load_data (data_in),
      .push      (push_s),
      .push_data (mem_rd_data),
      .pop       (core_pop_s),
      .head      (head_s),
      .count     (count_s)
   );

   assign to_cu      = to_cu_s;
   assign data_out   = (read_en & to_cu_valid) ? to_cu_s : {DATA_W{1'b0}};
   assign count      = count_s;
   assign mem_rd_req = req_r;
   assign overflow   = ovf_r;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ir_prefetch_queue
// Self-checking bench for ir_prefetch_queue (DATA_W=16, DEPTH=4): a table of
// directed cycles with hand-computed results, hand sequences for pointer wrap
// and (with IR_BYPASS_EN) same-cycle bypass, then random traffic checked every
// cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ir_prefetch_queue;

   localparam int DW = 16;
   localparam int DP = 4;
`ifdef IR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] mem_rd_data = '0;
   logic          mem_rd_valid = 1'b0;
   logic          mem_rd_req;
   logic          write_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          read_en = 1'b0;
   logic [DW-1:0] data_out;
   logic          flush = 1'b0;
   logic          cu_next = 1'b0;
   logic [DW-1:0] to_cu;
   logic          to_cu_valid;
   logic [2:0]    count;
   logic          overflow;

   ir_prefetch_queue #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .mem_rd_req(mem_rd_req), .write_en(write_en), .data_in(data_in),
      .read_en(read_en), .data_out(data_out), .flush(flush), .cu_next(cu_next),
      .to_cu(to_cu), .to_cu_valid(to_cu_valid), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rst;
      logic          mrv;
      logic [DW-1:0] md;
      logic          we;
      logic [DW-1:0] din;
      logic          re;
      logic          fl;
      logic          cn;
   } in_t;

   typedef struct packed {
      in_t           in;
      logic [2:0]    cnt;
      logic [DW-1:0] tocu;
      logic          vld;
      logic [DW-1:0] dout;
      logic          req;
      logic          ovf;
   } row_t;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   bit            m_ovf  = 1'b0;
   bit            m_req  = 1'b0;
   bit            m_init = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t mkin(input logic r, input logic mrv, input logic [DW-1:0] md,
                                input logic we, input logic [DW-1:0] din,
                                input logic re, input logic fl, input logic cn);
      in_t v;
      v.rst = r; v.mrv = mrv; v.md = md; v.we = we; v.din = din;
      v.re = re; v.fl = fl; v.cn = cn;
      return v;
   endfunction

   function automatic row_t mk(input in_t v, input logic [2:0] cnt, input logic [DW-1:0] tocu,
                               input logic vld, input logic [DW-1:0] dout,
                               input logic req, input logic ovf);
      row_t r;
      r.in = v; r.cnt = cnt; r.tocu = tocu; r.vld = vld; r.dout = dout;
      r.req = req; r.ovf = ovf;
      return r;
   endfunction

   function automatic bit m_hit(input in_t v);
      return BYP && !v.rst && !v.we && !v.fl && v.mrv && (mq.size() == 0);
   endfunction

   task automatic drive(input in_t v);
      rst = v.rst; mem_rd_valid = v.mrv; mem_rd_data = v.md; write_en = v.we;
      data_in = v.din; read_en = v.re; flush = v.fl; cu_next = v.cn;
   endtask

   // One clock cycle: drive, compare against the model before the edge, advance model.
   task automatic cycle(input in_t v);
      bit            hit;
      bit            vld;
      logic [DW-1:0] tc;
      bit            pop;
      bit            full;
      drive(v);
      #1;
      hit = m_hit(v);
      vld = (mq.size() > 0) || hit;
      tc  = (mq.size() > 0) ? mq[0] : (hit ? v.md : '0);
      if (m_init) begin
         chk("m_count",    32'(count),       32'(mq.size()));
         chk("m_valid",    32'(to_cu_valid), 32'(vld));
         chk("m_to_cu",    32'(to_cu),       32'(tc));
         chk("m_data_out", 32'(data_out),    32'((v.re && vld) ? tc : '0));
         chk("m_req",      32'(mem_rd_req),  32'(m_req));
         chk("m_overflow", 32'(overflow),    32'(m_ovf));
      end
      @(posedge clk);
      if (v.rst) begin
         mq.delete(); m_ovf = 1'b0; m_req = 1'b0; m_init = 1'b1;
      end else if (v.we) begin
         mq.delete(); mq.push_back(v.din); m_req = 1'b0;
      end else if (v.fl) begin
         mq.delete(); m_req = 1'b0;
      end else begin
         pop  = v.cn && vld;
         full = (mq.size() == DP);
         if (!(hit && v.cn)) begin
            if (pop) void'(mq.pop_front());
            if (v.mrv) begin
               if (!full || pop) mq.push_back(v.md);
               else m_ovf = 1'b1;
            end
         end
         m_req = (mq.size() < DP - 1);
      end
      @(negedge clk);
   endtask

   row_t tbl[23];
   in_t  idle;

   initial begin
      idle = mkin(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
      tbl[0]  = mk(mkin(1,0,16'h0,0,16'h0,0,0,0),    3'd0, 16'h0,    0, 16'h0,    0, 0);
      tbl[1]  = mk(mkin(1,0,16'h0,0,16'h0,0,0,0),    3'd0, 16'h0,    0, 16'h0,    0, 0);
      tbl[2]  = mk(idle,                             3'd0, 16'h0,    0, 16'h0,    1, 0);
      tbl[3]  = mk(mkin(0,1,16'h1111,0,16'h0,0,0,0), 3'd1, 16'h1111, 1, 16'h0,    1, 0);
      tbl[4]  = mk(mkin(0,1,16'h2222,0,16'h0,0,0,0), 3'd2, 16'h1111, 1, 16'h0,    1, 0);
      tbl[5]  = mk(mkin(0,1,16'h3333,0,16'h0,0,0,0), 3'd3, 16'h1111, 1, 16'h0,    0, 0);
      tbl[6]  = mk(mkin(0,1,16'h5555,0,16'h0,0,1,0), 3'd0, 16'h0,    0, 16'h0,    0, 0);
      tbl[7]  = mk(mkin(0,0,16'h0,1,16'h7E01,0,0,0), 3'd1, 16'h7E01, 1, 16'h0,    0, 0);
      tbl[8]  = mk(mkin(0,0,16'h0,0,16'h0,1,0,1),    3'd0, 16'h0,    0, 16'h0,    1, 0);
      tbl[9]  = mk(mkin(0,1,16'hA000,0,16'h0,0,0,0), 3'd1, 16'hA000, 1, 16'h0,    1, 0);
      tbl[10] = mk(mkin(0,1,16'hA001,0,16'h0,0,0,0), 3'd2, 16'hA000, 1, 16'h0,    1, 0);
      tbl[11] = mk(mkin(0,1,16'hA002,0,16'h0,0,0,0), 3'd3, 16'hA000, 1, 16'h0,    0, 0);
      tbl[12] = mk(mkin(0,1,16'hA003,0,16'h0,0,0,0), 3'd4, 16'hA000, 1, 16'h0,    0, 0);
      tbl[13] = mk(mkin(0,1,16'hBEEF,0,16'h0,0,0,1), 3'd4, 16'hA001, 1, 16'h0,    0, 0);
      tbl[14] = mk(mkin(0,1,16'hBEEF,0,16'h0,0,0,0), 3'd4, 16'hA001, 1, 16'h0,    0, 1);
      tbl[15] = mk(mkin(0,0,16'h0,0,16'h0,0,0,1),    3'd3, 16'hA002, 1, 16'h0,    0, 1);
      tbl[16] = mk(mkin(0,0,16'h0,0,16'h0,0,0,1),    3'd2, 16'hA003, 1, 16'h0,    1, 1);
      tbl[17] = mk(mkin(0,0,16'h0,0,16'h0,0,0,1),    3'd1, 16'hBEEF, 1, 16'h0,    1, 1);
      tbl[18] = mk(mkin(0,0,16'h0,0,16'h0,1,0,0),    3'd1, 16'hBEEF, 1, 16'hBEEF, 1, 1);
      tbl[19] = mk(mkin(0,0,16'h0,0,16'h0,0,0,1),    3'd0, 16'h0,    0, 16'h0,    1, 1);
      tbl[20] = mk(mkin(0,0,16'h0,1,16'h1234,0,0,0), 3'd1, 16'h1234, 1, 16'h0,    0, 1);
      tbl[21] = mk(mkin(0,0,16'h0,0,16'h0,1,0,0),    3'd1, 16'h1234, 1, 16'h1234, 1, 1);
      tbl[22] = mk(mkin(1,0,16'h0,0,16'h0,0,0,0),    3'd0, 16'h0,    0, 16'h0,    0, 0);

      @(negedge clk);

      // Directed table: each row is one cycle; results sampled after the edge
      // with state-changing inputs idle and read_en held.
      for (int i = 0; i < 23; i++) begin
         in_t s;
         cycle(tbl[i].in);
         s = idle;
         s.re = tbl[i].in.re;
         drive(s);
         #1;
         chk($sformatf("t%0d_count", i),    32'(count),       32'(tbl[i].cnt));
         chk($sformatf("t%0d_to_cu", i),    32'(to_cu),       32'(tbl[i].tocu));
         chk($sformatf("t%0d_valid", i),    32'(to_cu_valid), 32'(tbl[i].vld));
         chk($sformatf("t%0d_data_out", i), 32'(data_out),    32'(tbl[i].dout));
         chk($sformatf("t%0d_req", i),      32'(mem_rd_req),  32'(tbl[i].req));
         chk($sformatf("t%0d_overflow", i), 32'(overflow),    32'(tbl[i].ovf));
      end

      // Pointer wrap: one resident word, ten push+pop pairs keep FIFO order.
      cycle(mkin(0, 1, 16'h0100, 0, 16'h0, 0, 0, 0));
      for (int i = 1; i <= 10; i++) begin
         cycle(mkin(0, 1, 16'(16'h0100 + i), 0, 16'h0, 0, 0, 1));
         drive(idle);
         #1;
         chk($sformatf("wrap%0d_to_cu", i), 32'(to_cu), 32'(16'h0100 + i));
         chk($sformatf("wrap%0d_count", i), 32'(count), 32'd1);
      end

`ifdef IR_BYPASS_EN
      // Same-cycle bypass: empty queue, word consumed without being stored.
      cycle(mkin(1, 0, 16'h0, 0, 16'h0, 0, 0, 0));
      cycle(idle);
      drive(mkin(0, 1, 16'hC0DE, 0, 16'h0, 0, 0, 1));
      #1;
      chk("byp_to_cu", 32'(to_cu),       32'h0000C0DE);
      chk("byp_valid", 32'(to_cu_valid), 32'd1);
      chk("byp_count", 32'(count),       32'd0);
      cycle(mkin(0, 1, 16'hC0DE, 0, 16'h0, 0, 0, 1));
      drive(idle);
      #1;
      chk("byp_after_count", 32'(count),       32'd0);
      chk("byp_after_valid", 32'(to_cu_valid), 32'd0);
`endif

      // Random traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         in_t v;
         v.rst = ($urandom_range(0, 63) == 0);
         v.we  = ($urandom_range(0, 19) == 0);
         v.din = 16'($urandom);
         v.fl  = ($urandom_range(0, 19) == 0);
         v.mrv = ($urandom_range(0, 9) < 6);
         v.md  = 16'($urandom);
         v.cn  = ($urandom_range(0, 9) < 4);
         v.re  = ($urandom_range(0, 1) == 1);
         cycle(v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
